timer_counter: RTL and testbench

8-bit up/down timer counter for the 8-bit timer. Consumes the prescaled clock `int_clk` from the prescaler (`select_clock`) as a data input in the `clk` domain. Supports count enable, direction select and a parallel load from the data register. Provides sticky overflow and underflow flags for the status register.

---
 rtl/timer_counter.sv | 76 +++++++
 tb/tb_timer_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: 8-bit up/down timer counter for the 8-bit timer.
// The prescaled int_clk is treated as data in the clk domain. Its rising edge
// produces a one-cycle tick that advances the count. The block also supports
// a parallel load and keeps sticky overflow/underflow flags for the status
// register.
module timer_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             preset_n,
    input  logic             int_clk,
    input  logic             cnt_en,
    input  logic             up_dw,
    input  logic             load,
    input  logic [WIDTH-1:0] tdr,
    input  logic             clr_ovf,
    input  logic             clr_udf,
    output logic [WIDTH-1:0] cnt,
    output logic             tmr_ovf,
    output logic             tmr_udf
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             int_clk_q;
    logic             tick_c;

    // int_clk is derived from clk, so a single delay stage is enough for edge detection
    assign tick_c = int_clk & ~int_clk_q;

    // Next-state logic: load beats tick, and a flag set beats its clear
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q & ~clr_ovf;
        udf_d = udf_q & ~clr_udf;
        if (load) begin
            cnt_d = tdr;
        end else if (cnt_en && tick_c) begin
            if (!up_dw) begin
                cnt_d = cnt_q + WIDTH'(1);
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
                if (cnt_q == CNT_MIN) begin
                    udf_d = 1'b1;
                end
            end
        end
    end

    // State registers; the edge detector runs even while disabled or loading
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            int_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            int_clk_q <= int_clk;
        end
    end

    assign cnt     = cnt_q;
    assign tmr_ovf = ovf_q;
    assign tmr_udf = udf_q;

endmodule

// File: tb/tb_timer_counter.sv
// Testbench for timer_counter. It runs directed vectors with literal
// expectations, and an arithmetic reference model is compared on every
// falling clock edge.
module tb_timer_counter;

    logic       clk = 1'b0;
    logic       preset_n;
    logic       int_clk;
    logic       cnt_en;
    logic       up_dw;
    logic       load;
    logic [7:0] tdr;
    logic       clr_ovf;
    logic       clr_udf;
    logic [7:0] cnt;
    logic       tmr_ovf;
    logic       tmr_udf;

    int checks = 0;
    int errors = 0;

    timer_counter #(.WIDTH(8)) dut (
        .clk      (clk),
        .preset_n (preset_n),
        .int_clk  (int_clk),
        .cnt_en   (cnt_en),
        .up_dw    (up_dw),
        .load     (load),
        .tdr      (tdr),
        .clr_ovf  (clr_ovf),
        .clr_udf  (clr_udf),
        .cnt      (cnt),
        .tmr_ovf  (tmr_ovf),
        .tmr_udf  (tmr_udf)
    );

    always #5 clk = ~clk;

    // Reference model: integer count with explicit 0..255 wrap rules
    int m_cnt;
    bit m_ovf, m_udf, m_prev;
    always @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            m_cnt = 0; m_ovf = 0; m_udf = 0; m_prev = 0;
        end else begin
            bit rise, set_o, set_u;
            rise  = int_clk && !m_prev;
            set_o = 0;
            set_u = 0;
            if (load) m_cnt = int'(tdr);
            else if (cnt_en && rise) begin
                if (!up_dw) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt > 255) begin m_cnt = 0; set_o = 1; end
                end else begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt < 0) begin m_cnt = 255; set_u = 1; end
                end
            end
            m_ovf  = set_o ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
            m_udf  = set_u ? 1'b1 : (clr_udf ? 1'b0 : m_udf);
            m_prev = int_clk;
        end
    end

    // Compare the DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        checks++;
        if (cnt !== 8'(m_cnt) || tmr_ovf !== m_ovf || tmr_udf !== m_udf) begin
            errors++;
            $display("FAIL model t=%0t: cnt=%h ovf=%b udf=%b, want cnt=%h ovf=%b udf=%b",
                     $time, cnt, tmr_ovf, tmr_udf, 8'(m_cnt), m_ovf, m_udf);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One int_clk period of 2 clk cycles; count checked right after the counting edge
    task automatic pulse(input string name, input logic [7:0] exp);
        int_clk = 1'b1;
        step();
        chk(name, cnt, exp);
        int_clk = 1'b0;
        step();
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; tdr = v;
        step();
        load = 1'b0;
        chk("load", cnt, v);
    endtask

    initial begin
        preset_n = 1'b0; int_clk = 1'b0; cnt_en = 1'b1; up_dw = 1'b0;
        load = 1'b0; tdr = 8'h00; clr_ovf = 1'b0; clr_udf = 1'b0;

        // Reset held while enabled and int_clk toggling
        for (int i = 0; i < 6; i++) begin
            int_clk = ~int_clk;
            step();
            chk("rst_cnt", cnt, 8'h00);
            chk("rst_flags", {6'b0, tmr_ovf, tmr_udf}, 8'h00);
        end
        int_clk = 1'b0;
        preset_n = 1'b1;
        step();
        chk("post_rst_idle", cnt, 8'h00);
        pulse("first_inc", 8'h01);

        // Up-count overflow and clear
        do_load(8'hFD);
        pulse("up_fe", 8'hFE);
        chk("ovf_pre", {7'b0, tmr_ovf}, 8'h00);
        pulse("up_ff", 8'hFF);
        pulse("up_00", 8'h00);
        chk("ovf_set", {7'b0, tmr_ovf}, 8'h01);
        pulse("up_01", 8'h01);
        chk("ovf_sticky", {7'b0, tmr_ovf}, 8'h01);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr", {7'b0, tmr_ovf}, 8'h00);

        // Down-count underflow
        up_dw = 1'b1;
        do_load(8'h02);
        pulse("dn_01", 8'h01);
        pulse("dn_00", 8'h00);
        chk("udf_pre", {7'b0, tmr_udf}, 8'h00);
        pulse("dn_ff", 8'hFF);
        chk("udf_set", {7'b0, tmr_udf}, 8'h01);
        chk("ovf_quiet", {7'b0, tmr_ovf}, 8'h00);

        // Load wins over a tick in the same cycle
        up_dw = 1'b0;
        do_load(8'h10);
        int_clk = 1'b1; load = 1'b1; tdr = 8'h55;
        step();
        load = 1'b0;
        chk("load_prio", cnt, 8'h55);
        int_clk = 1'b0;
        step();
        pulse("after_load", 8'h56);
        chk("udf_kept", {7'b0, tmr_udf}, 8'h01);

        // Clear underflow
        clr_udf = 1'b1;
        step();
        clr_udf = 1'b0;
        chk("udf_clr", {7'b0, tmr_udf}, 8'h00);

        // Overflow set and clear in the same cycle: set wins
        do_load(8'hFF);
        int_clk = 1'b1; clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("coll_cnt", cnt, 8'h00);
        chk("coll_ovf", {7'b0, tmr_ovf}, 8'h01);
        int_clk = 1'b0;
        step();

        // Enable gating; re-enable while int_clk is high gives no spurious tick
        do_load(8'h20);
        cnt_en = 1'b0;
        for (int i = 0; i < 5; i++) pulse("gated", 8'h20);
        int_clk = 1'b1;
        step();
        cnt_en = 1'b1;
        step();
        chk("reen_high", cnt, 8'h20);
        int_clk = 1'b0;
        step();
        pulse("reen_inc", 8'h21);

        // Asynchronous reset mid-count
        pulse("pre_areset", 8'h22);
        #2 preset_n = 1'b0;
        #1 chk("areset_cnt", cnt, 8'h00);
        chk("areset_ovf", {7'b0, tmr_ovf}, 8'h00);
        step();
        step();
        preset_n = 1'b1;
        pulse("after_areset", 8'h01);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1);
    end

endmodule
